// File: rtl/qam_cfg_pkg.sv
// Shared definitions for the modulator rate-configuration sequencer:
// modulation and baud-rate codes, FSM state encoding, counter width.
package qam_cfg_pkg;

  localparam int CNT_W = 16;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_16QAM = 1'b1;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYM  = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_APPLY     = 3'd3,
    ST_RESET_DIV = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/sym_edge_sync.sv
// Brings the divider-derived symbol clock into the clk_in domain through a
// two-flop synchroniser and flags its rising edge with one extra delay flop.
module sym_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchroniser chain plus delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/qam_cfg_sequencer.sv
// Owns the modulator rate configuration feeding clk_gen and applies each
// change at a symbol boundary: wait for a symbol edge, hold TX, apply,
// reset the dividers, settle, release.
// Optional feature macro: CFG_TIMEOUT_EN bounds the wait for a symbol edge
// and raises a sticky err_timeout when it expires.
//
// Request handshake: a request transfers on any clk_in edge where
// req_valid && req_ready. req_ready is high only in IDLE; the requester
// holds req_* stable until the transfer. Changes to req_* after the
// transfer have no effect on the request in flight.
module qam_cfg_sequencer
  import qam_cfg_pkg::*;
#(
  parameter int DRAIN_CYC   = 4,
  parameter int DIV_RST_CYC = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mod_type,
  input  logic [1:0] req_baud_rate,
  input  logic       clk_symbol,
  output logic       cfg_mod_type,
  output logic [1:0] cfg_baud_rate,
  output logic       div_rst_n,
  output logic       tx_hold,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output state_t     fsm_state
);

  localparam logic [CNT_W-1:0] DRAIN_LD   = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_RST_LD = CNT_W'(DIV_RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pend_mod;
  logic [1:0]       pend_baud;
  logic             from_reset;
  logic             accept;
  logic             apply;
  logic             sym_rise;

  sym_edge_sync u_sym_edge_sync (
    .clk  (clk_in),
    .rst  (rst),
    .din  (clk_symbol),
    .rise (sym_rise)
  );

  assign fsm_state = state;

  // State, shared counter, pending request and applied configuration.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= ST_RESET_DIV;
      cnt           <= DIV_RST_LD;
      cfg_mod_type  <= MOD_QPSK;
      cfg_baud_rate <= BAUD_2400;
      pend_mod      <= MOD_QPSK;
      pend_baud     <= BAUD_2400;
      from_reset    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        pend_mod   <= req_mod_type;
        pend_baud  <= req_baud_rate;
        from_reset <= 1'b0;
      end
      if (apply) begin
        cfg_mod_type  <= pend_mod;
        cfg_baud_rate <= pend_baud;
      end
    end
  end

`ifdef CFG_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
  logic set_err;

  // Sticky timeout flag, cleared when the next request is accepted.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (accept) begin
      err_timeout <= 1'b0;
    end else if (set_err) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  // Next-state, counter reload/decrement and Moore outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    apply     = 1'b0;
    req_ready = 1'b0;
    tx_hold   = 1'b1;
    div_rst_n = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
`ifdef CFG_TIMEOUT_EN
    set_err   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        tx_hold   = 1'b0;
        busy      = 1'b0;
        if (req_valid) begin
          accept = 1'b1;
          // Identical configuration needs no disruption of the TX path.
          if (req_mod_type == cfg_mod_type && req_baud_rate == cfg_baud_rate) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_WAIT_SYM;
`ifdef CFG_TIMEOUT_EN
            cnt_nxt   = TIMEOUT_LD;
`else
            cnt_nxt   = '0;
`endif
          end
        end
      end
      ST_WAIT_SYM: begin
        tx_hold = 1'b0;
        if (sym_rise) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LD;
        end
`ifdef CFG_TIMEOUT_EN
        else if (cnt == '0) begin
          set_err   = 1'b1;
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
`endif
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_nxt = ST_APPLY;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_APPLY: begin
        apply     = 1'b1;
        state_nxt = ST_RESET_DIV;
        cnt_nxt   = DIV_RST_LD;
      end
      ST_RESET_DIV: begin
        div_rst_n = 1'b0;
        if (cnt == '0) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          // The power-up sequence ends silently; only requests report done.
          state_nxt = from_reset ? ST_IDLE : ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        tx_hold   = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_RESET_DIV;
        cnt_nxt   = DIV_RST_LD;
      end
    endcase
  end

  // Illegal parameter values are caught in simulation.
  always_ff @(posedge clk_in) begin
    assert (DRAIN_CYC >= 1 && DIV_RST_CYC >= 1 && SETTLE_CYC >= 1 &&
            TIMEOUT_CYC >= 1 && TIMEOUT_CYC <= 65535);
  end

endmodule

// File: tb/tb_qam_cfg_sequencer.sv
// Directed bench for qam_cfg_sequencer with default timing parameters
// (DRAIN 4, DIV_RST 2, SETTLE 16, TIMEOUT 20000).
module tb_qam_cfg_sequencer;
  import qam_cfg_pkg::*;

  logic       clk_in;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_mod_type;
  logic [1:0] req_baud_rate;
  logic       clk_symbol;
  logic       cfg_mod_type;
  logic [1:0] cfg_baud_rate;
  logic       div_rst_n;
  logic       tx_hold;
  logic       busy;
  logic       done;
  logic       err_timeout;
  state_t     fsm_state;

  int vectors;
  int miscompares;

  qam_cfg_sequencer dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mod_type  (req_mod_type),
    .req_baud_rate (req_baud_rate),
    .clk_symbol    (clk_symbol),
    .cfg_mod_type  (cfg_mod_type),
    .cfg_baud_rate (cfg_baud_rate),
    .div_rst_n     (div_rst_n),
    .tx_hold       (tx_hold),
    .busy          (busy),
    .done          (done),
    .err_timeout   (err_timeout),
    .fsm_state     (fsm_state)
  );

  // Clock and reset block: 10 ns clock, inputs driven and outputs sampled
  // on the falling edge.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called one falling edge after a clk_in edge with rst high.
  // Cycle 1 is the first cycle with rst low.
  task automatic reset_seq();
    check("rst_cfg", 32'({cfg_mod_type, cfg_baud_rate}), 32'h0);
    check("rst_div", 32'(div_rst_n), 32'd0);
    check("rst_txh", 32'(tx_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdy", 32'(req_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      if (i > 1) tick();
      check($sformatf("pwr_div_c%0d", i), 32'(div_rst_n), 32'(i > 2));
      check($sformatf("pwr_txh_c%0d", i), 32'(tx_hold), 32'(i <= 18));
      check($sformatf("pwr_rdy_c%0d", i), 32'(req_ready), 32'(i == 19));
      check($sformatf("pwr_done_c%0d", i), 32'(done), 32'd0);
    end
    check("pwr_cfg", 32'({cfg_mod_type, cfg_baud_rate}), 32'h0);
  endtask

  // Request equal to the current configuration: done on the cycle after accept.
  task automatic same_cfg(input logic m, input logic [1:0] b);
    req_valid = 1'b1;
    req_mod_type = m;
    req_baud_rate = b;
    check("same_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("same_done", 32'(done), 32'd1);
    check("same_txh", 32'(tx_hold), 32'd0);
    check("same_div", 32'(div_rst_n), 32'd1);
    check("same_rdy_busy", 32'(req_ready), 32'd0);
    check("same_err", 32'(err_timeout), 32'd0);
    tick();
    check("same_done_end", 32'(done), 32'd0);
    check("same_txh_end", 32'(tx_hold), 32'd0);
    check("same_rdy_end", 32'(req_ready), 32'd1);
    check("same_cfg", 32'({cfg_mod_type, cfg_baud_rate}), 32'({m, b}));
  endtask

  // Drive a clean rising edge on clk_symbol; returns on the cycle where the
  // synchronised edge is visible to the FSM (cycle E), still in WAIT_SYM.
  task automatic sym_edge();
    clk_symbol = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_txh", 32'(tx_hold), 32'd0);
      check("wait_state", 32'(fsm_state), 32'(ST_WAIT_SYM));
    end
    clk_symbol = 1'b1;
    tick();
    check("wait_txh_s1", 32'(tx_hold), 32'd0);
    tick();
    check("wait_state_e", 32'(fsm_state), 32'(ST_WAIT_SYM));
  endtask

  // From cycle E walk the change sequence up to E+last.
  task automatic change_seq(input logic [2:0] old_cfg, input logic [2:0] new_cfg, input int last);
    check("e_txh", 32'(tx_hold), 32'd0);
    for (int j = 1; j <= last; j++) begin
      tick();
      check($sformatf("chg_txh_e%0d", j), 32'(tx_hold), 32'(j < 24));
      check($sformatf("chg_div_e%0d", j), 32'(div_rst_n), 32'(!(j == 6 || j == 7)));
      check($sformatf("chg_done_e%0d", j), 32'(done), 32'(j == 24));
      check($sformatf("chg_rdy_e%0d", j), 32'(req_ready), 32'd0);
      check($sformatf("chg_cfg_e%0d", j), 32'({cfg_mod_type, cfg_baud_rate}),
            32'((j >= 6) ? new_cfg : old_cfg));
    end
  endtask

  // Directed test sequence.
  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_mod_type = 1'b0;
    req_baud_rate = 2'b00;
    clk_symbol = 1'b0;
    repeat (3) tick();

    // Power-up sequence.
    reset_seq();

    // Same configuration request: immediate done, no disruption.
    same_cfg(MOD_QPSK, BAUD_2400);

    // Change to 16QAM / 19200.
    req_valid = 1'b1;
    req_mod_type = MOD_16QAM;
    req_baud_rate = BAUD_19200;
    tick();
    req_valid = 1'b0;
    check("c3_rdy", 32'(req_ready), 32'd0);
    check("c3_busy", 32'(busy), 32'd1);
    sym_edge();
    change_seq(3'b000, 3'b111, 24);
    tick();
    check("c3_rdy_end", 32'(req_ready), 32'd1);
    check("c3_done_end", 32'(done), 32'd0);
    check("c3_cfg_end", 32'({cfg_mod_type, cfg_baud_rate}), 32'h7);

    // Request held valid through busy; changed fields must not leak in.
    req_valid = 1'b1;
    req_mod_type = MOD_QPSK;
    req_baud_rate = BAUD_4800;
    clk_symbol = 1'b0;
    tick();
    check("c4_state", 32'(fsm_state), 32'(ST_WAIT_SYM));
    req_mod_type = MOD_16QAM;
    req_baud_rate = BAUD_9600;
    sym_edge();
    change_seq(3'b111, 3'b001, 24);
    tick();
    check("c4_rdy_idle", 32'(req_ready), 32'd1);
    check("c4_cfg_first", 32'({cfg_mod_type, cfg_baud_rate}), 32'h1);
    tick();
    req_valid = 1'b0;
    check("c4_second_acc", 32'(fsm_state), 32'(ST_WAIT_SYM));
    check("c4_busy", 32'(busy), 32'd1);

    // Second request (16QAM / 9600) interrupted by reset during SETTLE.
    sym_edge();
    change_seq(3'b001, 3'b110, 10);
    check("c5_settle", 32'(fsm_state), 32'(ST_SETTLE));
    rst = 1'b1;
    tick();
    reset_seq();

    // Same configuration after reset.
    same_cfg(MOD_QPSK, BAUD_2400);

`ifdef CFG_TIMEOUT_EN
    // Symbol clock stuck low: timeout forces the change through.
    clk_symbol = 1'b0;
    repeat (3) tick();
    req_valid = 1'b1;
    req_mod_type = MOD_QPSK;
    req_baud_rate = BAUD_4800;
    tick();
    req_valid = 1'b0;
    repeat (19999) tick();
    check("to_err_before", 32'(err_timeout), 32'd0);
    check("to_state_before", 32'(fsm_state), 32'(ST_WAIT_SYM));
    change_seq(3'b000, 3'b001, 24);
    check("to_err_set", 32'(err_timeout), 32'd1);
    tick();
    check("to_err_sticky", 32'(err_timeout), 32'd1);
    same_cfg(MOD_QPSK, BAUD_4800);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
